// File: rtl/sram_arbiter.sv
// sram_arbiter: clean/record writers and a play reader share one SRAM; 4-cycle access.
// Define SRAM_ARB_RR_EN to alternate record and play grants when both are pending.
module sram_arbiter #(
    parameter int ADDR_W       = 20,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cln_req,
    input  logic [ADDR_W-1:0] i_cln_addr,
    input  logic [DATA_W-1:0] i_cln_wdata,
    output logic              o_cln_ack,
    input  logic              i_rec_req,
    input  logic [ADDR_W-1:0] i_rec_addr,
    input  logic [DATA_W-1:0] i_rec_wdata,
    output logic              o_rec_ack,
    input  logic              i_ply_req,
    input  logic [ADDR_W-1:0] i_ply_addr,
    output logic              o_ply_ack,
    output logic [DATA_W-1:0] o_ply_rdata,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_wdata,
    output logic              o_sram_oe_dq,
    input  logic [DATA_W-1:0] i_sram_rdata,
    output logic              o_sram_we_n,
    output logic              o_busy,
    output logic [1:0]        o_grant,
    output logic              o_ply_starve,
    input  logic              i_clr_starve
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_DONE
    } state_t;

    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_CLN  = 2'b01;
    localparam logic [1:0] G_REC  = 2'b10;
    localparam logic [1:0] G_PLY  = 2'b11;

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STARVE_LIMIT - 1);

    state_t            state_q, state_d;
    logic [1:0]        win, grant_q;
    logic              grant_en, done;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q, sel_addr;
    logic [DATA_W-1:0] wdata_q, sel_wdata, rdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              starve_q, ply_gnt, ply_wait, starve_set;

`ifdef SRAM_ARB_RR_EN
    logic rr_q;  // 0: record goes first on a record/play tie
`endif

    always_comb begin
        win = G_NONE;
        if (i_cln_req) begin
            win = G_CLN;
        end else if (i_rec_req && i_ply_req) begin
`ifdef SRAM_ARB_RR_EN
            win = rr_q ? G_PLY : G_REC;
`else
            win = G_REC;
`endif
        end else if (i_rec_req) begin
            win = G_REC;
        end else if (i_ply_req) begin
            win = G_PLY;
        end
    end

    always_comb begin
        sel_addr  = i_ply_addr;
        sel_wdata = i_rec_wdata;
        unique case (win)
            G_CLN: begin
                sel_addr  = i_cln_addr;
                sel_wdata = i_cln_wdata;
            end
            G_REC: sel_addr = i_rec_addr;
            default: ;
        endcase
    end

    assign grant_en = (state_q == S_IDLE) && (win != G_NONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        o_busy       = 1'b1;
        o_sram_we_n  = 1'b1;
        o_sram_oe_dq = wr_q;
        done         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                o_busy       = 1'b0;
                o_sram_oe_dq = 1'b0;
                if (win != G_NONE) state_d = S_SETUP;
            end
            S_SETUP: state_d = S_STROBE;
            S_STROBE: begin
                o_sram_we_n = ~wr_q;
                state_d     = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            grant_q <= G_NONE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (grant_en) begin
                grant_q <= win;
                addr_q  <= sel_addr;
                wr_q    <= (win != G_PLY);
                if (win != G_PLY) wdata_q <= sel_wdata;
            end else if (state_q == S_DONE) begin
                grant_q <= G_NONE;
            end
            if (state_q == S_STROBE && !wr_q) rdata_q <= i_sram_rdata;
        end
    end

`ifdef SRAM_ARB_RR_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_q <= 1'b0;
        end else if (grant_en && win != G_CLN) begin
            rr_q <= ~rr_q;
        end
    end
`endif

    // Flag fires on reaching the limit, so a saturated counter cannot re-set it.
    assign ply_gnt    = (grant_q == G_PLY) || (grant_en && win == G_PLY);
    assign ply_wait   = i_ply_req && !ply_gnt;
    assign starve_set = ply_wait && (cnt_q == CNT_PRE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q    <= '0;
            starve_q <= 1'b0;
        end else begin
            if (!ply_wait) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (starve_set) begin
                starve_q <= 1'b1;
            end else if (i_clr_starve) begin
                starve_q <= 1'b0;
            end
        end
    end

    assign o_cln_ack    = done && (grant_q == G_CLN);
    assign o_rec_ack    = done && (grant_q == G_REC);
    assign o_ply_ack    = done && (grant_q == G_PLY);
    assign o_grant      = grant_q;
    assign o_sram_addr  = addr_q;
    assign o_sram_wdata = wdata_q;
    assign o_ply_rdata  = rdata_q;
    assign o_ply_starve = starve_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and random accesses checked against a transaction-level model.
// Honours SRAM_ARB_RR_EN for the record/play tie-break expectations.
module tb_sram_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int SL = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cln_req, rec_req, ply_req;
    logic [AW-1:0] cln_addr, rec_addr, ply_addr;
    logic [DW-1:0] cln_wdata, rec_wdata;
    logic          cln_ack, rec_ack, ply_ack;
    logic [DW-1:0] ply_rdata;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;
    logic          sram_oe, sram_we_n;
    logic          busy, starve, clr_starve;
    logic [1:0]    grant;

    int n_run  = 0;
    int n_fail = 0;

    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] last_rd;
`ifdef SRAM_ARB_RR_EN
    logic rr_ptr;
`endif

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cln_req(cln_req), .i_cln_addr(cln_addr),
        .i_cln_wdata(cln_wdata), .o_cln_ack(cln_ack),
        .i_rec_req(rec_req), .i_rec_addr(rec_addr),
        .i_rec_wdata(rec_wdata), .o_rec_ack(rec_ack),
        .i_ply_req(ply_req), .i_ply_addr(ply_addr),
        .o_ply_ack(ply_ack), .o_ply_rdata(ply_rdata),
        .o_sram_addr(sram_addr), .o_sram_wdata(sram_wdata),
        .o_sram_oe_dq(sram_oe), .i_sram_rdata(sram_rdata),
        .o_sram_we_n(sram_we_n), .o_busy(busy), .o_grant(grant),
        .o_ply_starve(starve), .i_clr_starve(clr_starve)
    );

    always #5 clk = ~clk;

    // SRAM model: asynchronous read, write captured while WE_n is low
    assign sram_rdata = mem[sram_addr[7:0]];
    always @(negedge clk) if (!sram_we_n) mem[sram_addr[7:0]] <= sram_wdata;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] pick();
        if (cln_req) return 2'd1;
        if (rec_req && ply_req) begin
`ifdef SRAM_ARB_RR_EN
            return rr_ptr ? 2'd3 : 2'd2;
`else
            return 2'd2;
`endif
        end
        if (rec_req) return 2'd2;
        if (ply_req) return 2'd3;
        return 2'd0;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_we_n"}, 32'(sram_we_n), 32'd1);
        chk({tag, "_oe"}, 32'(sram_oe), 32'd0);
        chk({tag, "_addr"}, 32'(sram_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(sram_wdata), 32'd0);
        chk({tag, "_acks"}, 32'({cln_ack, rec_ack, ply_ack}), 32'd0);
        chk({tag, "_rdata"}, 32'(ply_rdata), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_starve"}, 32'(starve), 32'd0);
    endtask

    task automatic do_reset();
        {cln_req, rec_req, ply_req, clr_starve} = '0;
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        last_rd = '0;
`ifdef SRAM_ARB_RR_EN
        rr_ptr = 1'b0;
`endif
    endtask

    // Called at the negedge of an IDLE cycle; returns at the next IDLE negedge.
    task automatic one_access(input bit drop_ply, input bit hold_win);
        logic [1:0]    w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            wr;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_grant", 32'(grant), 32'd0);
        chk("idle_oe", 32'(sram_oe), 32'd0);
        chk("idle_acks", 32'({cln_ack, rec_ack, ply_ack}), 32'd0);
        chk("idle_rdata", 32'(ply_rdata), 32'(last_rd));
        w = pick();
        if (w == 2'd0) begin
            @(negedge clk);
            return;
        end
        a  = (w == 2'd1) ? cln_addr : (w == 2'd2) ? rec_addr : ply_addr;
        d  = (w == 2'd1) ? cln_wdata : rec_wdata;
        wr = (w != 2'd3);
`ifdef SRAM_ARB_RR_EN
        if (w != 2'd1) rr_ptr = ~rr_ptr;
`endif
        @(negedge clk);
        chk("setup_grant", 32'(grant), 32'(w));
        chk("setup_busy", 32'(busy), 32'd1);
        chk("setup_addr", 32'(sram_addr), 32'(a));
        chk("setup_oe", 32'(sram_oe), 32'(wr));
        chk("setup_we_n", 32'(sram_we_n), 32'd1);
        chk("setup_acks", 32'({cln_ack, rec_ack, ply_ack}), 32'd0);
        unique case (w)
            2'd1: begin cln_addr = AW'($urandom); cln_wdata = DW'($urandom); end
            2'd2: begin rec_addr = AW'($urandom); rec_wdata = DW'($urandom); end
            default: ply_addr = AW'($urandom);
        endcase
        if (drop_ply) ply_req = 1'b0;
        @(negedge clk);
        chk("strobe_grant", 32'(grant), 32'(w));
        chk("strobe_addr", 32'(sram_addr), 32'(a));
        chk("strobe_we_n", 32'(sram_we_n), 32'(!wr));
        chk("strobe_oe", 32'(sram_oe), 32'(wr));
        if (wr) chk("strobe_wdata", 32'(sram_wdata), 32'(d));
        chk("strobe_acks", 32'({cln_ack, rec_ack, ply_ack}), 32'd0);
        chk("strobe_rdata", 32'(ply_rdata), 32'(last_rd));
        @(negedge clk);
        chk("done_we_n", 32'(sram_we_n), 32'd1);
        chk("done_oe", 32'(sram_oe), 32'(wr));
        chk("done_busy", 32'(busy), 32'd1);
        if (wr) chk("done_wdata", 32'(sram_wdata), 32'(d));
        chk("done_acks", 32'({cln_ack, rec_ack, ply_ack}),
            32'({w == 2'd1, w == 2'd2, w == 2'd3}));
        if (wr) ref_mem[a[7:0]] = d;
        else last_rd = ref_mem[a[7:0]];
        chk("done_rdata", 32'(ply_rdata), 32'(last_rd));
        if (!hold_win) begin
            unique case (w)
                2'd1: cln_req = 1'b0;
                2'd2: rec_req = 1'b0;
                default: ply_req = 1'b0;
            endcase
        end
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] prev_g, exp_g;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = DW'($urandom);
            ref_mem[i] = mem[i];
        end
        rst_n = 1'b1;
        {cln_addr, rec_addr, ply_addr} = '0;
        {cln_wdata, rec_wdata} = '0;
        #2;
        do_reset();

        rec_req = 1'b1; rec_addr = 20'h00010; rec_wdata = 16'hBEEF;
        one_access(1'b0, 1'b0);
        chk("w_beef_mem", 32'(mem[8'h10]), 32'h0000BEEF);

        ply_req = 1'b1; ply_addr = 20'h00010;
        one_access(1'b0, 1'b0);
        chk("r_beef_rdata", 32'(ply_rdata), 32'h0000BEEF);

        {cln_req, rec_req, ply_req} = 3'b111;
        cln_addr = 20'h00021; cln_wdata = 16'h1234;
        rec_addr = 20'h00022; rec_wdata = 16'h5678;
        ply_addr = 20'h00021;
        repeat (4) one_access(1'b0, 1'b0);
        chk("tri_rdata", 32'(ply_rdata), 32'h00001234);

        cln_req = 1'b1; ply_req = 1'b1;
        cln_addr = 20'h00030; cln_wdata = 16'hC1EA;
        one_access(1'b1, 1'b0);
        repeat (2) one_access(1'b0, 1'b0);

        for (int it = 0; it < 60; it++) begin
            if (!cln_req) begin
                cln_req = ($urandom_range(0, 2) == 0);
                cln_addr = AW'($urandom); cln_wdata = DW'($urandom);
            end
            if (!rec_req) begin
                rec_req = ($urandom_range(0, 1) == 0);
                rec_addr = AW'($urandom); rec_wdata = DW'($urandom);
            end
            if (!ply_req) begin
                ply_req = ($urandom_range(0, 1) == 0);
                ply_addr = AW'($urandom);
            end
            one_access(1'b0, 1'b0);
        end

        do_reset();
        rec_req = 1'b1; ply_req = 1'b1;
        prev_g = 2'd0; exp_g = 2'd2;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
`ifdef SRAM_ARB_RR_EN
            chk("starve_rr", 32'(starve), 32'd0);
            if (grant != 2'd0 && prev_g == 2'd0) begin
                chk("rr_alt", 32'(grant), 32'(exp_g));
                exp_g = (exp_g == 2'd2) ? 2'd3 : 2'd2;
            end
            prev_g = grant;
`else
            chk("starve_cnt", 32'(starve), 32'(k >= SL));
`endif
        end
        clr_starve = 1'b1;
        @(negedge clk);
        clr_starve = 1'b0;
        chk("starve_clr", 32'(starve), 32'd0);
        repeat (8) begin
            @(negedge clk);
            chk("starve_stay0", 32'(starve), 32'd0);
        end

`ifndef SRAM_ARB_RR_EN
        do_reset();
        rec_req = 1'b1; ply_req = 1'b1;
        repeat (SL - 1) @(negedge clk);
        chk("starve_pre", 32'(starve), 32'd0);
        clr_starve = 1'b1;
        @(negedge clk);
        clr_starve = 1'b0;
        chk("starve_set_wins", 32'(starve), 32'd1);
        ply_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("starve_sticky", 32'(starve), 32'd1);
        clr_starve = 1'b1;
        @(negedge clk);
        clr_starve = 1'b0;
        chk("starve_clr2", 32'(starve), 32'd0);
`endif

        do_reset();
        rec_req = 1'b1; rec_addr = 20'h00123; rec_wdata = 16'hA5A5;
        @(negedge clk);
        @(negedge clk);
        chk("abort_strobe_we_n", 32'(sram_we_n), 32'd0);
        #1 rst_n = 1'b0;
        rec_req = 1'b0;
        #1 chk_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_ack", 32'({cln_ack, rec_ack, ply_ack}), 32'd0);
            chk("abort_idle", 32'(busy), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, 20, SRAM address width; DATA_W, 16, SRAM data width; STARVE_LIMIT, 64, play-wait cycles before starvation flag.
REQ-002 SHALL have ports: i_clk  in  1  system clock (single clock domain); i_rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have clean-writer ports: i_cln_req in 1 request; i_cln_addr in ADDR_W; i_cln_wdata in DATA_W; o_cln_ack out 1 access-complete pulse.
REQ-004 SHALL have recorder-writer ports: i_rec_req in 1; i_rec_addr in ADDR_W; i_rec_wdata in DATA_W; o_rec_ack out 1.
REQ-005 SHALL have player-reader ports: i_ply_req in 1; i_ply_addr in ADDR_W; o_ply_ack out 1; o_ply_rdata out DATA_W, read word, valid with o_ply_ack.
REQ-006 SHALL have SRAM-side ports: o_sram_addr out ADDR_W; o_sram_wdata out DATA_W; o_sram_oe_dq out 1, top-level DQ tri-state enable; i_sram_rdata in DATA_W, DQ input; o_sram_we_n out 1.
REQ-007 SHALL have status ports: o_busy out 1, access in progress; o_grant out 2 (00 none, 01 clean, 10 record, 11 play); o_ply_starve out 1 sticky; i_clr_starve in 1.

Function
REQ-008 SHALL implement FSM IDLE -> SETUP -> STROBE -> DONE -> IDLE; each non-IDLE state lasts exactly one cycle.
REQ-009 In IDLE with >=1 request, SHALL pick winner, latch its address, write data and direction, set o_grant, and go to SETUP; with no request, SHALL stay in IDLE, o_grant=00.
REQ-010 Default arbitration SHALL be fixed priority clean > record > play.
REQ-011 SETUP: o_sram_addr = latched address; write: o_sram_oe_dq=1, o_sram_we_n=1 (address setup).
REQ-012 STROBE: write: o_sram_we_n=0, DQ driven; read: DQ not driven, i_sram_rdata registered at end of cycle.
REQ-013 DONE: o_sram_we_n=1, write data held driven (hold time), winner's ack pulses high for exactly one cycle; for read, o_ply_rdata = registered word.
REQ-014 Request-to-ack latency SHALL be 4 cycles from the IDLE cycle sampling req; back-to-back throughput one access per 4 cycles.
REQ-015 o_sram_oe_dq SHALL be 0 in IDLE and for all read cycles; o_sram_we_n SHALL be low only in STROBE of a write.
REQ-016 Requester holds req, addr, wdata stable until ack; changes after grant latch SHALL be ignored; requester deasserts req in the cycle after ack or is re-arbitrated in the next IDLE.
REQ-017 A req dropped before grant SHALL cause no SRAM access and no ack.
REQ-018 Simultaneous requests: only the winner proceeds; losers remain pending without ack.
REQ-019 o_busy SHALL be 1 in SETUP, STROBE, DONE.
REQ-020 Starvation counter SHALL increment each cycle i_ply_req=1 and play not granted, clear on play grant or req low, saturate at STARVE_LIMIT; reaching STARVE_LIMIT SHALL set o_ply_starve, cleared only by i_clr_starve or reset; i_clr_starve same cycle as set-condition: set wins.
REQ-021 o_ply_rdata SHALL hold its value until the next play DONE.

Reset
REQ-022 Reset assertion SHALL take effect immediately, mid-access included: state IDLE, o_sram_we_n=1, o_sram_oe_dq=0, o_sram_addr=0, o_sram_wdata=0, all acks 0, o_ply_rdata=0, o_busy=0, o_grant=00, o_ply_starve=0, counter 0.
REQ-023 An access aborted by reset SHALL never be acked; requester re-issues after reset.

Configuration
REQ-024 With SRAM_ARB_RR_EN defined, record and play SHALL alternate (round-robin pointer toggles after each record or play grant, reset points to record) when both pending; clean keeps absolute priority.
REQ-025 Without SRAM_ARB_RR_EN, REQ-010 fixed priority SHALL apply and no pointer register exists.

Verification
REQ-026 Single record write addr 0x00010 data 0xBEEF -> we_n low exactly 1 cycle with addr 0x00010, DQ 0xBEEF; o_rec_ack at cycle 4.
REQ-027 Play read addr 0x00010, SRAM model returns 0xBEEF -> o_ply_ack at cycle 4, o_ply_rdata=0xBEEF, o_sram_oe_dq=0 throughout.
REQ-028 Clean, record, play asserted same cycle -> grants 01, 10, 11 in order, acks at cycles 4, 8, 12 (fixed priority).
REQ-029 Record held continuously, play held (fixed priority) -> o_ply_starve=1 after 64 cycles; i_clr_starve -> 0; with SRAM_ARB_RR_EN, grants alternate 10/11 and o_ply_starve stays 0.
REQ-030 Reset asserted during STROBE of a write -> o_sram_we_n=1, o_sram_oe_dq=0 same cycle, no ack after release.
REQ-031 Play req dropped in SETUP of a clean access -> no play access, no o_ply_ack.
